// File: rtl/otter_intr_ctrl_if.sv
// IOBUS slice seen by the interrupt controller: CPU address/write data/strobe
// in one direction, window select and read data in the other.
interface otter_intr_ctrl_if;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic        io_sel;
  logic [31:0] io_rdata;

  modport master (
    output iobus_addr, iobus_out, iobus_wr,
    input  io_sel, io_rdata
  );

  modport slave (
    input  iobus_addr, iobus_out, iobus_wr,
    output io_sel, io_rdata
  );
endinterface

// File: rtl/otter_intr_ctrl.sv
// Memory-mapped interrupt controller for the OTTER MCU: synchronises and latches
// N_SRC request lines, picks the highest-priority enabled one, runs claim/complete.
module otter_intr_ctrl #(
  parameter int          N_SRC     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h1100_0200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  otter_intr_ctrl_if.slave bus,
  output logic             intr,
  output logic             in_service
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  localparam logic [2:0] OFF_PENDING  = 3'd0;
  localparam logic [2:0] OFF_ENABLE   = 3'd1;
  localparam logic [2:0] OFF_TRIGGER  = 3'd2;
  localparam logic [2:0] OFF_CLAIM    = 3'd3;
  localparam logic [2:0] OFF_COMPLETE = 3'd4;

  state_t           state_reg, state_next;
  logic [N_SRC-1:0] sync1_reg, sync2_reg, sync2_d_reg;
  logic [N_SRC-1:0] pending_reg, pending_next;
  logic [N_SRC-1:0] enable_reg, trigger_reg;
  logic [4:0]       isr_id_reg;
  logic             intr_reg;

  logic [N_SRC-1:0] rise, set_vec, cand, w1c_clr, claim_clr;
  logic [4:0]       best;
  logic             valid;
  logic             hit;
  logic [2:0]       off;
  logic             wr_pending, wr_enable, wr_trigger, wr_claim, wr_complete;
  logic             claim_fire;
  logic             unused_bits;

  assign hit = (bus.iobus_addr[31:5] == BASE_ADDR[31:5]);
  assign off = bus.iobus_addr[4:2];

  assign wr_pending  = bus.iobus_wr && hit && (off == OFF_PENDING);
  assign wr_enable   = bus.iobus_wr && hit && (off == OFF_ENABLE);
  assign wr_trigger  = bus.iobus_wr && hit && (off == OFF_TRIGGER);
  assign wr_claim    = bus.iobus_wr && hit && (off == OFF_CLAIM);
  assign wr_complete = bus.iobus_wr && hit && (off == OFF_COMPLETE);

  // Byte lanes and bits above the source count carry no state.
  assign unused_bits = ^{bus.iobus_out, bus.iobus_addr[1:0]};

  assign rise    = sync2_reg & ~sync2_d_reg;
  assign set_vec = (trigger_reg & rise) | (~trigger_reg & sync2_reg);
  assign cand    = pending_reg & enable_reg;
  assign valid   = |cand;
  assign w1c_clr = wr_pending ? bus.iobus_out[N_SRC-1:0] : '0;

  // Lowest index wins, so scan from the top and let later hits overwrite.
  always_comb begin
    best = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i]) best = 5'(i);
    end
  end

  assign claim_fire = wr_claim && valid && (state_reg == S_ASSERT);

  // A new set on the same edge always beats W1C or claim clears.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pending
      assign claim_clr[gi]    = claim_fire && (best == 5'(gi));
      assign pending_next[gi] = set_vec[gi] |
                                (pending_reg[gi] & ~w1c_clr[gi] & ~claim_clr[gi]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      sync2_d_reg <= '0;
      pending_reg <= '0;
      enable_reg  <= '0;
      trigger_reg <= '0;
      isr_id_reg  <= '0;
      state_reg   <= S_IDLE;
      intr_reg    <= 1'b0;
    end else begin
      sync1_reg   <= irq_src;
      sync2_reg   <= sync1_reg;
      sync2_d_reg <= sync2_reg;
      pending_reg <= pending_next;
      if (wr_enable)  enable_reg  <= bus.iobus_out[N_SRC-1:0];
      if (wr_trigger) trigger_reg <= bus.iobus_out[N_SRC-1:0];
      if (claim_fire) isr_id_reg  <= best;
      state_reg   <= state_next;
      intr_reg    <= (state_next == S_ASSERT);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (valid) state_next = S_ASSERT;
      end
      S_ASSERT: begin
        if (!valid)          state_next = S_IDLE;
        else if (claim_fire) state_next = S_SERVICE;
      end
      S_SERVICE: begin
        // Only the matching id retires the ISR; no nesting while in service.
        if (wr_complete && (bus.iobus_out[4:0] == isr_id_reg)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign intr       = intr_reg;
  assign in_service = (state_reg == S_SERVICE);

  always_comb begin
    bus.io_rdata = '0;
    if (hit) begin
      case (off)
        OFF_PENDING: bus.io_rdata = {{(32-N_SRC){1'b0}}, pending_reg};
        OFF_ENABLE:  bus.io_rdata = {{(32-N_SRC){1'b0}}, enable_reg};
        OFF_TRIGGER: bus.io_rdata = {{(32-N_SRC){1'b0}}, trigger_reg};
        OFF_CLAIM:   bus.io_rdata = {valid, 26'b0, best};
        default:     bus.io_rdata = '0;
      endcase
    end
  end

  assign bus.io_sel = hit;

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Directed bench for otter_intr_ctrl: latency, priority, claim/complete,
// level re-assert, set-vs-clear races, async reset and address decode.
module tb_otter_intr_ctrl;

  localparam logic [31:0] BASE = 32'h1100_0200;
  localparam logic [31:0] A_PEND  = BASE + 32'h00;
  localparam logic [31:0] A_EN    = BASE + 32'h04;
  localparam logic [31:0] A_TRIG  = BASE + 32'h08;
  localparam logic [31:0] A_CLAIM = BASE + 32'h0C;
  localparam logic [31:0] A_COMP  = BASE + 32'h10;
  localparam logic [31:0] A_RSV   = BASE + 32'h14;

  logic       clk;
  logic       rst;
  logic [7:0] irq_src;
  logic       intr;
  logic       in_service;
  logic [31:0] rd;

  int n_checks;
  int n_fail;

  otter_intr_ctrl_if bus ();

  otter_intr_ctrl #(.N_SRC(8), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_src    (irq_src),
    .bus        (bus.slave),
    .intr       (intr),
    .in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.iobus_addr = a;
    bus.iobus_out  = d;
    bus.iobus_wr   = 1'b1;
    @(negedge clk);
    bus.iobus_wr   = 1'b0;
  endtask

  task automatic rdreg(input logic [31:0] a, output logic [31:0] d);
    bus.iobus_addr = a;
    #1;
    d = bus.io_rdata;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    irq_src = '0;
    bus.iobus_addr = '0;
    bus.iobus_out  = '0;
    bus.iobus_wr   = 1'b0;
    step(2);
    rst = 1'b0;

    check("reset_intr", {31'b0, intr}, 32'h0);
    check("reset_in_service", {31'b0, in_service}, 32'h0);
    rdreg(A_PEND, rd);  check("reset_pending", rd, 32'h0);
    rdreg(A_CLAIM, rd); check("reset_claim", rd, 32'h0);

    // 1: single edge source, latency
    wr(A_EN, 32'h01);
    wr(A_TRIG, 32'h01);
    irq_src[0] = 1'b1;
    step(1);
    irq_src[0] = 1'b0;
    step(2);
    rdreg(A_PEND, rd); check("t1_pending_edge3", rd, 32'h01);
    check("t1_intr_edge3", {31'b0, intr}, 32'h0);
    step(1);
    check("t1_intr_edge4", {31'b0, intr}, 32'h1);
    rdreg(A_CLAIM, rd); check("t1_claim", rd, 32'h8000_0000);
    wr(A_CLAIM, 32'h0);
    wr(A_COMP, 32'h0);
    check("t1_done_in_service", {31'b0, in_service}, 32'h0);

    // 2: priority, claim, mismatched and matching complete
    wr(A_EN, 32'hFF);
    wr(A_TRIG, 32'hFF);
    rdreg(A_EN, rd); check("t2_enable_rb", rd, 32'hFF);
    irq_src = 8'h24;
    step(1);
    irq_src = 8'h00;
    step(3);
    check("t2_intr", {31'b0, intr}, 32'h1);
    rdreg(A_CLAIM, rd); check("t2_claim_best2", rd, 32'h8000_0002);
    wr(A_CLAIM, 32'h0);
    check("t2_intr_after_claim", {31'b0, intr}, 32'h0);
    check("t2_in_service", {31'b0, in_service}, 32'h1);
    rdreg(A_PEND, rd); check("t2_pending_after_claim", rd, 32'h20);
    wr(A_COMP, 32'h5);
    check("t2_wrong_complete_in_service", {31'b0, in_service}, 32'h1);
    check("t2_wrong_complete_intr", {31'b0, intr}, 32'h0);
    wr(A_COMP, 32'h2);
    check("t2_complete_in_service", {31'b0, in_service}, 32'h0);
    step(1);
    check("t2_intr_reassert", {31'b0, intr}, 32'h1);
    rdreg(A_CLAIM, rd); check("t2_claim_best5", rd, 32'h8000_0005);
    wr(A_CLAIM, 32'h0);
    wr(A_COMP, 32'h5);

    // 3: level source re-asserts after completion
    wr(A_TRIG, 32'hF7);
    irq_src[3] = 1'b1;
    step(4);
    check("t3_intr", {31'b0, intr}, 32'h1);
    rdreg(A_CLAIM, rd); check("t3_claim", rd, 32'h8000_0003);
    wr(A_CLAIM, 32'h0);
    check("t3_in_service", {31'b0, in_service}, 32'h1);
    rdreg(A_PEND, rd); check("t3_pending_level_held", rd, 32'h08);
    wr(A_COMP, 32'h3);
    step(1);
    check("t3_intr_reassert", {31'b0, intr}, 32'h1);
    irq_src[3] = 1'b0;
    step(3);
    wr(A_PEND, 32'h08);
    step(1);
    rdreg(A_PEND, rd); check("t3_pending_w1c", rd, 32'h0);
    check("t3_intr_drop", {31'b0, intr}, 32'h0);

    // 4: set beats W1C on the same edge; disable during ASSERT
    irq_src[1] = 1'b1;
    step(1);
    irq_src[1] = 1'b0;
    step(1);
    wr(A_PEND, 32'h02);
    rdreg(A_PEND, rd); check("t4_set_wins", rd, 32'h02);
    step(1);
    check("t4_intr", {31'b0, intr}, 32'h1);
    wr(A_EN, 32'h00);
    step(1);
    check("t4_intr_disabled", {31'b0, intr}, 32'h0);
    rdreg(A_PEND, rd);  check("t4_pending_kept", rd, 32'h02);
    rdreg(A_CLAIM, rd); check("t4_claim_invalid", rd, 32'h0);

    // 5: asynchronous reset mid-service
    wr(A_EN, 32'h02);
    step(1);
    check("t5_intr", {31'b0, intr}, 32'h1);
    wr(A_CLAIM, 32'h0);
    check("t5_in_service", {31'b0, in_service}, 32'h1);
    rst = 1'b1;
    #1;
    check("t5_rst_intr", {31'b0, intr}, 32'h0);
    check("t5_rst_in_service", {31'b0, in_service}, 32'h0);
    rdreg(A_PEND, rd); check("t5_rst_pending", rd, 32'h0);
    rdreg(A_EN, rd);   check("t5_rst_enable", rd, 32'h0);
    rdreg(A_TRIG, rd); check("t5_rst_trigger", rd, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 6: address decode
    rdreg(A_RSV, rd); check("t6_reserved_rdata", rd, 32'h0);
    check("t6_reserved_sel", {31'b0, bus.io_sel}, 32'h1);
    rdreg(32'h1100_0300, rd); check("t6_outside_hi_rdata", rd, 32'h0);
    check("t6_outside_hi_sel", {31'b0, bus.io_sel}, 32'h0);
    rdreg(32'h1100_01FC, rd);
    check("t6_outside_lo_sel", {31'b0, bus.io_sel}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
